xy_tracker: RTL and testbench

XY_TRACKER -- requirements
Module: xy_tracker

---
 rtl/xy_tracker.sv | 156 +++++++++++++++
 tb/tb_xy_tracker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/xy_tracker.sv
// Pixel-scan tracker: locks onto an x-y counter at (0,0) and follows it, emitting linear addresses.
// Optional saturating error counter is enabled by defining XY_TRACKER_ERRCNT_EN.
module xy_tracker #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               enable,
    input  logic [$clog2(WIDTH)-1:0]           x,
    input  logic [$clog2(HEIGHT)-1:0]          y,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]    addr,
    output logic                               valid,
    output logic                               line_end,
    output logic                               frame_end,
    output logic                               locked,
    output logic                               error,
    output logic [7:0]                         frame_count
`ifdef XY_TRACKER_ERRCNT_EN
    ,
    output logic [7:0]                         error_count
`endif
);

    localparam int X_W = $clog2(WIDTH);
    localparam int Y_W = $clog2(HEIGHT);
    localparam int A_W = $clog2(WIDTH * HEIGHT);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [X_W-1:0] ex_reg, ex_next;
    logic [Y_W-1:0] ey_reg, ey_next;
    logic [A_W-1:0] addr_reg, addr_next;
    logic           valid_reg, valid_next;
    logic           line_end_reg, line_end_next;
    logic           frame_end_reg, frame_end_next;
    logic           error_reg, error_next;
    logic [7:0]     frame_count_reg, frame_count_next;

    logic           accept;
    logic           at_last_col;
    logic           at_last_row;
    logic [A_W-1:0] addr_calc;

    // An accepted sample always equals the expected coordinate, so the raw inputs are
    // in range here; the product is formed at full address width and cannot overflow.
    assign addr_calc   = A_W'(y) * A_W'(WIDTH) + A_W'(x);
    assign at_last_col = (x == X_W'(WIDTH - 1));
    assign at_last_row = (y == Y_W'(HEIGHT - 1));

    always_comb begin
        state_next       = state_reg;
        ex_next          = ex_reg;
        ey_next          = ey_reg;
        addr_next        = addr_reg;
        valid_next       = 1'b0;
        line_end_next    = 1'b0;
        frame_end_next   = 1'b0;
        error_next       = 1'b0;
        frame_count_next = frame_count_reg;
        accept           = 1'b0;

        if (enable) begin
            case (state_reg)
                SEARCH: begin
                    if (x == '0 && y == '0) begin
                        state_next = LOCKED;
                        accept     = 1'b1;
                    end
                end
                LOCKED: begin
                    if (x == ex_reg && y == ey_reg) begin
                        accept = 1'b1;
                    end else begin
                        // A mismatch never relocks in the same cycle, even at (0,0).
                        state_next = SEARCH;
                        error_next = 1'b1;
                        ex_next    = '0;
                        ey_next    = '0;
                    end
                end
                default: begin
                    state_next = SEARCH;
                end
            endcase
        end

        if (accept) begin
            valid_next     = 1'b1;
            addr_next      = addr_calc;
            line_end_next  = at_last_col;
            frame_end_next = at_last_col && at_last_row;
            if (at_last_col && at_last_row) begin
                frame_count_next = frame_count_reg + 8'd1;
            end
            if (at_last_col) begin
                ex_next = '0;
                ey_next = at_last_row ? '0 : y + 1'b1;
            end else begin
                ex_next = x + 1'b1;
                ey_next = y;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= SEARCH;
            ex_reg          <= '0;
            ey_reg          <= '0;
            addr_reg        <= '0;
            valid_reg       <= 1'b0;
            line_end_reg    <= 1'b0;
            frame_end_reg   <= 1'b0;
            error_reg       <= 1'b0;
            frame_count_reg <= 8'd0;
        end else begin
            state_reg       <= state_next;
            ex_reg          <= ex_next;
            ey_reg          <= ey_next;
            addr_reg        <= addr_next;
            valid_reg       <= valid_next;
            line_end_reg    <= line_end_next;
            frame_end_reg   <= frame_end_next;
            error_reg       <= error_next;
            frame_count_reg <= frame_count_next;
        end
    end

`ifdef XY_TRACKER_ERRCNT_EN
    logic [7:0] error_count_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            error_count_reg <= 8'd0;
        end else if (error_next && error_count_reg != 8'hFF) begin
            error_count_reg <= error_count_reg + 8'd1;
        end
    end

    assign error_count = error_count_reg;
`endif

    assign addr        = addr_reg;
    assign valid       = valid_reg;
    assign line_end    = line_end_reg;
    assign frame_end   = frame_end_reg;
    assign locked      = (state_reg == LOCKED);
    assign error       = error_reg;
    assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_xy_tracker.sv
// Testbench for xy_tracker (WIDTH=5, HEIGHT=3): directed and random scans checked against a
// linear-position reference model.
module tb_xy_tracker;

    localparam int W = 5;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic [2:0] x;
    logic [1:0] y;
    logic [3:0] addr;
    logic       valid;
    logic       line_end;
    logic       frame_end;
    logic       locked;
    logic       error;
    logic [7:0] frame_count;
`ifdef XY_TRACKER_ERRCNT_EN
    logic [7:0] error_count;
`endif

    xy_tracker #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .x           (x),
        .y           (y),
        .addr        (addr),
        .valid       (valid),
        .line_end    (line_end),
        .frame_end   (frame_end),
        .locked      (locked),
        .error       (error),
        .frame_count (frame_count)
`ifdef XY_TRACKER_ERRCNT_EN
        ,
        .error_count (error_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int nstep = 0;

    // Reference model: lock flag plus linear scan position of the next expected sample.
    int m_locked = 0;
    int m_pos    = 0;
    int m_addr   = 0;
    int m_fc     = 0;
    int m_ec     = 0;

    // Free-running x-y counter used as the stimulus source.
    int cx = 0;
    int cy = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (step %0d)", tag, obs, exp, nstep);
        end
    endtask

    task automatic step(input logic en, input int xi, input int yi);
        int e_valid, e_le, e_fe, e_err;
        logic [31:0] xv, yv;
        xv = xi;
        yv = yi;
        enable = en;
        x = xv[2:0];
        y = yv[1:0];
        @(posedge clock);
        #1;
        nstep++;
        e_valid = 0; e_le = 0; e_fe = 0; e_err = 0;
        if (en) begin
            if (m_locked == 0) begin
                if (xi == 0 && yi == 0) begin
                    m_locked = 1;
                    m_pos    = 0;
                    e_valid  = 1;
                end
            end else if (xi == m_pos % W && yi == m_pos / W) begin
                e_valid = 1;
            end else begin
                m_locked = 0;
                e_err    = 1;
                if (m_ec < 255) m_ec++;
            end
            if (e_valid == 1) begin
                m_addr = m_pos;
                e_le   = (m_pos % W == W - 1) ? 1 : 0;
                e_fe   = (m_pos == N - 1) ? 1 : 0;
                if (e_fe == 1) m_fc = (m_fc + 1) % 256;
                m_pos  = (m_pos + 1) % N;
            end
        end
        $display("step %0d en=%0b x=%0d y=%0d valid=%0b addr=%0d le=%0b fe=%0b lk=%0b err=%0b fc=%0d",
                 nstep, en, xi, yi, valid, addr, line_end, frame_end, locked, error, frame_count);
        chk("valid", valid, e_valid);
        chk("addr", addr, m_addr);
        chk("line_end", line_end, e_le);
        chk("frame_end", frame_end, e_fe);
        chk("locked", locked, m_locked);
        chk("error", error, e_err);
        chk("frame_count", frame_count, m_fc);
`ifdef XY_TRACKER_ERRCNT_EN
        chk("error_count", error_count, m_ec);
`endif
    endtask

    task automatic cstep(input logic en);
        step(en, cx, cy);
        if (en) begin
            if (cx == W - 1) begin
                cx = 0;
                cy = (cy == H - 1) ? 0 : cy + 1;
            end else begin
                cx = cx + 1;
            end
        end
    endtask

    // Reset is asserted mid-cycle so that its effect is visible before any clock edge.
    task automatic do_reset();
        enable  = 1'b0;
        reset_n = 1'b0;
        #1;
        $display("reset asserted");
        chk("rst_addr", addr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_line_end", line_end, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_locked", locked, 0);
        chk("rst_error", error, 0);
        chk("rst_frame_count", frame_count, 0);
`ifdef XY_TRACKER_ERRCNT_EN
        chk("rst_error_count", error_count, 0);
`endif
        m_locked = 0; m_pos = 0; m_addr = 0; m_fc = 0; m_ec = 0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;
        x       = '0;
        y       = '0;
        @(posedge clock);
        #1;
        do_reset();

        // Continuous scan from (0,0): one full frame and one extra sample.
        cx = 0; cy = 0;
        for (int i = 0; i < N + 1; i++) cstep(1'b1);
        chk("fc_after_frame", frame_count, 1);

        // Enable gaps: 6 on, 2 off.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) cstep(1'b1);
            for (int i = 0; i < 2; i++) cstep(1'b0);
        end

        // Force a wrong column while the tracker expects (2,1), then let the counter relock it.
        for (int i = 0; i < 2 * N && !(cx == 2 && cy == 1); i++) cstep(1'b1);
        step(1'b1, 3, 1);
        for (int i = 0; i < N + 4; i++) cstep(1'b1);

        // A mismatching (0,0) must not relock immediately; the next (0,0) does.
        step(1'b1, 0, 0);
        step(1'b1, 0, 0);
        cx = 1; cy = 0;
        for (int i = 0; i < 4; i++) cstep(1'b1);

        // Start after reset mid-frame at (3,2): nothing until (0,0) arrives.
        do_reset();
        cx = 3; cy = 2;
        for (int i = 0; i < 8; i++) cstep(1'b1);

        // Reset pulsed while at address 7, then relock from (0,0).
        for (int i = 0; i < 2 * N && !(m_locked == 1 && m_addr == 7); i++) cstep(1'b1);
        do_reset();
        cx = 0; cy = 0;
        for (int i = 0; i < 6; i++) cstep(1'b1);

        // Random mix of counter scans, gaps, glitches, jumps and out-of-range coordinates.
        for (int i = 0; i < 400; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 65) begin
                cstep($urandom_range(0, 3) != 0);
            end else if (r < 80) begin
                step(1'b1, $urandom_range(0, 7), $urandom_range(0, 3));
            end else if (r < 88) begin
                cx = $urandom_range(0, W - 1);
                cy = $urandom_range(0, H - 1);
                cstep(1'b1);
            end else if (r < 94) begin
                cx = 0; cy = 0;
                cstep(1'b1);
            end else begin
                step(1'b0, $urandom_range(0, 7), $urandom_range(0, 3));
            end
        end

`ifdef XY_TRACKER_ERRCNT_EN
        // 300 forced mismatches: lock at (0,0), then present a wrong coordinate.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 0, 0);
            step(1'b1, 1, 1);
        end
        chk("error_count_sat", error_count, 255);
        step(1'b1, 0, 0);
        step(1'b1, 2, 2);
        chk("error_count_hold", error_count, 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
